// File: rtl/mul_flag_if.sv
// mul_flag_if: handshake/bus bundle between the program sequencer, the
// multiplier flag outputs and the multiplier status/flag register.
//   Sequencer -> register : ps_mul_en/cls/sc (decode-cycle op info),
//                           ps_mfl_wr_en, ps_mfl_sel, xb_dt_in (transfers),
//                           ps_mfl_cond (condition select), ps_mfl_irq_ack
//   Multiplier -> register: mul_ps_mv/mn/mu (execute cycle), mul_ps_mi (decode)
//   Register -> sequencer : mfl_xb_dt, mfl_ps_cond_true, mfl_ps_irq
// Modports: master = driving side (sequencer/multiplier), slave = flag register.
interface mul_flag_if #(
  parameter int RF_DATASIZE = 16
) ();
  logic                   ps_mul_en;
  logic [1:0]             ps_mul_cls;
  logic [1:0]             ps_mul_sc;
  logic                   mul_ps_mv;
  logic                   mul_ps_mn;
  logic                   mul_ps_mu;
  logic                   mul_ps_mi;
  logic                   ps_mfl_wr_en;
  logic                   ps_mfl_sel;
  logic [RF_DATASIZE-1:0] xb_dt_in;
  logic [RF_DATASIZE-1:0] mfl_xb_dt;
  logic [2:0]             ps_mfl_cond;
  logic                   mfl_ps_cond_true;
  logic                   ps_mfl_irq_ack;
  logic                   mfl_ps_irq;

  modport master (
    output ps_mul_en, ps_mul_cls, ps_mul_sc,
    output mul_ps_mv, mul_ps_mn, mul_ps_mu, mul_ps_mi,
    output ps_mfl_wr_en, ps_mfl_sel, xb_dt_in, ps_mfl_cond, ps_mfl_irq_ack,
    input  mfl_xb_dt, mfl_ps_cond_true, mfl_ps_irq
  );

  modport slave (
    input  ps_mul_en, ps_mul_cls, ps_mul_sc,
    input  mul_ps_mv, mul_ps_mn, mul_ps_mu, mul_ps_mi,
    input  ps_mfl_wr_en, ps_mfl_sel, xb_dt_in, ps_mfl_cond, ps_mfl_irq_ack,
    output mfl_xb_dt, mfl_ps_cond_true, mfl_ps_irq
  );
endinterface

// File: rtl/mul_flag_reg.sv
// mul_flag_reg: multiplier status/flag register stage.
// Aligns multiplier flags to the execute cycle and latches them into the
// arithmetic status field ASTAT = {MI, MU, MN, MV} and the sticky field
// STKY = {MIS, MUS, MVS}. Both are readable/writable over the transfer bus
// and ASTAT drives the conditional-instruction evaluation.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-low reset
//   mfl   - mul_flag_if.slave (op info, multiplier flags, bus, cond, irq)
// Optional feature: define MUL_FLAG_IRQ_EN to add the STKY[6:4] interrupt
// mask and the mfl_ps_irq request; without it mfl_ps_irq is tied low.
module mul_flag_reg #(
  parameter int RF_DATASIZE = 16
) (
  input  logic      clk,
  input  logic      reset,
  mul_flag_if.slave mfl
);

  function automatic logic cond_eval(input logic [2:0] sel, input logic [3:0] astat);
    case (sel)
      3'b000:  return astat[0];
      3'b001:  return ~astat[0];
      3'b010:  return astat[1];
      3'b011:  return ~astat[1];
      3'b100:  return astat[2];
      3'b101:  return astat[3];
      3'b110:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic       upd_vld_p0_d, upd_vld_p0_q;
  logic       mi_p0_d, mi_p0_q;
  logic [3:0] astat_d, astat_q;
  logic [2:0] stky_d, stky_q;
  logic [2:0] stky_set;
  logic       astat_wr, stky_wr;
  logic [2:0] mask_rd;
  logic [RF_DATASIZE-1:0] rd_data;

  // ---- Decode stage (p0): qualify the op; MR transfers (cls 00, sc != 11) never update flags
  always_comb begin
    upd_vld_p0_d = mfl.ps_mul_en & ~((mfl.ps_mul_cls == 2'b00) & (mfl.ps_mul_sc != 2'b11));
    mi_p0_d      = mfl.mul_ps_mi & mfl.ps_mul_en;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_vld_p0_q <= 1'b0;
      mi_p0_q      <= 1'b0;
    end else begin
      upd_vld_p0_q <= upd_vld_p0_d;
      mi_p0_q      <= mi_p0_d;
    end
  end

  // ---- Execute stage: latch flags into ASTAT/STKY at the closing edge
  always_comb begin
    astat_wr = mfl.ps_mfl_wr_en & ~mfl.ps_mfl_sel;
    stky_wr  = mfl.ps_mfl_wr_en &  mfl.ps_mfl_sel;
    // Sticky sets are taken even when a bus write overrides the ASTAT update.
    stky_set = upd_vld_p0_q ? {mi_p0_q, mfl.mul_ps_mu, mfl.mul_ps_mv} : 3'b000;

    astat_d = astat_q;
    if (astat_wr) begin
      astat_d = mfl.xb_dt_in[3:0];
    end else if (upd_vld_p0_q) begin
      astat_d = {mi_p0_q, mfl.mul_ps_mu, mfl.mul_ps_mn, mfl.mul_ps_mv};
    end

    // A bus write to STKY merges with same-cycle sets so no event is lost.
    stky_d = (stky_wr ? mfl.xb_dt_in[2:0] : stky_q) | stky_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      astat_q <= 4'b0000;
      stky_q  <= 3'b000;
    end else begin
      astat_q <= astat_d;
      stky_q  <= stky_d;
    end
  end

`ifdef MUL_FLAG_IRQ_EN
  logic [2:0] mask_d, mask_q;
  logic [2:0] stky_rise;
  logic       irq_d, irq_q;

  always_comb begin
    mask_d    = stky_wr ? mfl.xb_dt_in[6:4] : mask_q;
    // Any masked 0->1 sticky transition, whether from the multiplier or a bus write.
    stky_rise = stky_d & ~stky_q & mask_q;
    irq_d     = irq_q;
    if (|stky_rise) begin
      irq_d = 1'b1;
    end else if (mfl.ps_mfl_irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= 3'b000;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign mask_rd        = mask_q;
  assign mfl.mfl_ps_irq = irq_q;
`else
  assign mask_rd        = 3'b000;
  assign mfl.mfl_ps_irq = 1'b0;
`endif

  // Bus bits with no storage behind them and the ack when unused.
  logic unused_bits;
  assign unused_bits = ^{mfl.xb_dt_in, mfl.ps_mfl_irq_ack};

  always_comb begin
    rd_data = '0;
    if (mfl.ps_mfl_sel) begin
      rd_data[2:0] = stky_q;
      rd_data[6:4] = mask_rd;
    end else begin
      rd_data[3:0] = astat_q;
    end
  end

  assign mfl.mfl_xb_dt        = rd_data;
  assign mfl.mfl_ps_cond_true = cond_eval(mfl.ps_mfl_cond, astat_q);

endmodule

// File: tb/tb_mul_flag_reg.sv
module tb_mul_flag_reg;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mul_flag_if #(.RF_DATASIZE(W)) mfl ();

  mul_flag_reg #(.RF_DATASIZE(W)) dut (
    .clk   (clk),
    .reset (reset),
    .mfl   (mfl)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model state: architectural view of the register plus the ops in flight.
  typedef struct packed {
    bit vld;
    bit mi;
  } op_t;

  op_t      inflight[$];
  bit [3:0] m_astat;
  bit [2:0] m_stky;
  bit [2:0] m_mask;
  bit       m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_cond(input bit [2:0] c, input bit [3:0] a);
    bit mv, mn, mu, mi;
    {mi, mu, mn, mv} = a;
    case (c)
      3'd0: return mv;
      3'd1: return !mv;
      3'd2: return mn;
      3'd3: return !mn;
      3'd4: return mu;
      3'd5: return mi;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [W-1:0] exp_rd(input bit sel);
    if (sel) return {9'd0, m_mask, 1'b0, m_stky};
    return {12'd0, m_astat};
  endfunction

  task automatic model_reset();
    m_astat = '0;
    m_stky  = '0;
    m_mask  = '0;
    m_irq   = 1'b0;
    inflight.delete();
  endtask

  // One clock: derive what the register must hold after the edge from the
  // inputs presented now, then advance.
  task automatic step();
    op_t      issued, exec;
    bit [2:0] sets, n_stky, n_mask, rise;
    bit [3:0] n_astat;
    bit       n_irq;
    bit       wr_a, wr_s;

    issued.vld = mfl.ps_mul_en && !(mfl.ps_mul_cls == 2'b00 && mfl.ps_mul_sc != 2'b11);
    issued.mi  = mfl.mul_ps_mi && mfl.ps_mul_en;
    exec = '0;
    if (inflight.size() > 0) exec = inflight.pop_front();

    wr_a = mfl.ps_mfl_wr_en && !mfl.ps_mfl_sel;
    wr_s = mfl.ps_mfl_wr_en &&  mfl.ps_mfl_sel;

    sets = exec.vld ? {exec.mi, mfl.mul_ps_mu, mfl.mul_ps_mv} : 3'b000;

    if (wr_a)          n_astat = mfl.xb_dt_in[3:0];
    else if (exec.vld) n_astat = {exec.mi, mfl.mul_ps_mu, mfl.mul_ps_mn, mfl.mul_ps_mv};
    else               n_astat = m_astat;

    n_stky = (wr_s ? mfl.xb_dt_in[2:0] : m_stky) | sets;

    n_mask = m_mask;
    n_irq  = 1'b0;
`ifdef MUL_FLAG_IRQ_EN
    if (wr_s) n_mask = mfl.xb_dt_in[6:4];
    rise  = n_stky & ~m_stky & m_mask;
    n_irq = (rise != 0) ? 1'b1 : (mfl.ps_mfl_irq_ack ? 1'b0 : m_irq);
`else
    rise  = 3'b000;
`endif
    inflight.push_back(issued);

    @(posedge clk);
    #1;
    if (reset) begin
      m_astat = n_astat;
      m_stky  = n_stky;
      m_mask  = n_mask;
      m_irq   = n_irq;
    end else begin
      model_reset();
    end
  endtask

  task automatic issue(input bit en, input bit [1:0] cls, input bit [1:0] sc, input bit mi);
    mfl.ps_mul_en  = en;
    mfl.ps_mul_cls = cls;
    mfl.ps_mul_sc  = sc;
    mfl.mul_ps_mi  = mi;
  endtask

  task automatic flags(input bit mv, input bit mn, input bit mu);
    mfl.mul_ps_mv = mv;
    mfl.mul_ps_mn = mn;
    mfl.mul_ps_mu = mu;
  endtask

  task automatic bus_wr(input bit sel, input bit [W-1:0] data);
    mfl.ps_mfl_wr_en = 1'b1;
    mfl.ps_mfl_sel   = sel;
    mfl.xb_dt_in     = data;
    step();
    mfl.ps_mfl_wr_en = 1'b0;
    mfl.xb_dt_in     = '0;
  endtask

  task automatic rd_check(input string name, input bit sel, input bit [W-1:0] exp);
    mfl.ps_mfl_sel = sel;
    #1;
    check(name, mfl.mfl_xb_dt, exp);
  endtask

  task automatic cond_check(input string name, input bit [2:0] c, input bit exp);
    mfl.ps_mfl_cond = c;
    #1;
    check(name, mfl.mfl_ps_cond_true, exp);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_rd", mfl.mfl_xb_dt, exp_rd(mfl.ps_mfl_sel));
      check("cyc_cond", mfl.mfl_ps_cond_true, exp_cond(mfl.ps_mfl_cond, m_astat));
      check("cyc_irq", mfl.mfl_ps_irq, m_irq);
    end
  end

  initial begin
    issue(0, 2'b01, 2'b00, 0);
    flags(0, 0, 0);
    mfl.ps_mfl_wr_en   = 1'b0;
    mfl.ps_mfl_sel     = 1'b0;
    mfl.xb_dt_in       = '0;
    mfl.ps_mfl_cond    = 3'b000;
    mfl.ps_mfl_irq_ack = 1'b0;

    #1 reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    step();
    rd_check("rst_astat", 0, 16'h0000);
    rd_check("rst_stky", 1, 16'h0000);
    cond_check("rst_c110", 3'b110, 1'b1);
    cond_check("rst_c000", 3'b000, 1'b0);
    check("rst_irq", mfl.mfl_ps_irq, 1'b0);
    step();
    reset = 1'b1;
    step();

    // Product op: MV, MN
    issue(1, 2'b01, 2'b00, 0); step();
    issue(0, 2'b01, 2'b00, 0); flags(1, 1, 0); step();
    flags(0, 0, 0);
    rd_check("t1_astat", 0, 16'h0003);
    rd_check("t1_stky", 1, 16'h0001);
    cond_check("t1_c000", 3'b000, 1'b1);
    cond_check("t1_c011", 3'b011, 1'b0);

    // MR1 read: no update even with all flags forced
    issue(1, 2'b00, 2'b01, 1); step();
    issue(0, 2'b01, 2'b00, 0); flags(1, 1, 1); step();
    flags(0, 0, 0);
    rd_check("t2_astat", 0, 16'h0003);
    rd_check("t2_stky", 1, 16'h0001);

    // MI from decode cycle, then a clean op
    bus_wr(1, 16'h0000);
    issue(1, 2'b01, 2'b00, 1); step();
    issue(0, 2'b01, 2'b00, 0); step();
    rd_check("t3_astat", 0, 16'h0008);
    rd_check("t3_stky", 1, 16'h0004);
    cond_check("t3_c101", 3'b101, 1'b1);
    issue(1, 2'b10, 2'b00, 0); step();
    issue(0, 2'b01, 2'b00, 0); step();
    rd_check("t3_clean_astat", 0, 16'h0000);
    rd_check("t3_clean_stky", 1, 16'h0004);

    // Bus STKY write coinciding with MU update
    issue(1, 2'b01, 2'b00, 0); step();
    issue(0, 2'b01, 2'b00, 0); flags(0, 0, 1);
    bus_wr(1, 16'h0000);
    flags(0, 0, 0);
    rd_check("t4_stky", 1, 16'h0002);
    rd_check("t4_astat", 0, 16'h0004);
    cond_check("t4_c100", 3'b100, 1'b1);

    // Bus ASTAT write coinciding with MV update
    issue(1, 2'b00, 2'b11, 0); step();
    issue(0, 2'b01, 2'b00, 0); flags(1, 0, 0);
    bus_wr(0, 16'h0000);
    flags(0, 0, 0);
    rd_check("t4_astat_wr", 0, 16'h0000);
    rd_check("t4_stky_or", 1, 16'h0003);

    // Reserved bits ignored
    bus_wr(0, 16'hFFFF);
    rd_check("t4_astat_ff", 0, 16'h000F);
    bus_wr(1, 16'hFFFF);
`ifdef MUL_FLAG_IRQ_EN
    rd_check("t4_stky_ff", 1, 16'h0077);
`else
    rd_check("t4_stky_ff", 1, 16'h0007);
`endif
    bus_wr(1, 16'h0000);

    // Back-to-back ops, then disabled cycles hold
    issue(1, 2'b01, 2'b00, 0); step();
    issue(1, 2'b11, 2'b00, 0); flags(1, 0, 0); step();
    rd_check("t5_b2b_1", 0, 16'h0001);
    issue(0, 2'b01, 2'b00, 0); flags(0, 1, 0); step();
    rd_check("t5_b2b_2", 0, 16'h0002);
    flags(1, 1, 1); step(); step();
    flags(0, 0, 0);
    rd_check("t5_hold", 0, 16'h0002);
    rd_check("t5_hold_stky", 1, 16'h0001);

`ifdef MUL_FLAG_IRQ_EN
    bus_wr(1, 16'h0010);
    issue(1, 2'b01, 2'b00, 0); step();
    issue(0, 2'b01, 2'b00, 0); flags(1, 0, 0); step();
    flags(0, 0, 0);
    check("irq_set", mfl.mfl_ps_irq, 1'b1);
    step(); step();
    check("irq_held", mfl.mfl_ps_irq, 1'b1);
    mfl.ps_mfl_irq_ack = 1'b1; step(); mfl.ps_mfl_irq_ack = 1'b0;
    check("irq_ack", mfl.mfl_ps_irq, 1'b0);

    bus_wr(1, 16'h0010);
    issue(1, 2'b01, 2'b00, 0); step();
    issue(0, 2'b01, 2'b00, 0); flags(1, 0, 0); mfl.ps_mfl_irq_ack = 1'b1; step();
    flags(0, 0, 0); mfl.ps_mfl_irq_ack = 1'b0;
    check("irq_set_wins", mfl.mfl_ps_irq, 1'b1);
    mfl.ps_mfl_irq_ack = 1'b1; step(); mfl.ps_mfl_irq_ack = 1'b0;

    bus_wr(1, 16'h0010);
    issue(1, 2'b01, 2'b00, 0); step();
    issue(0, 2'b01, 2'b00, 0); flags(0, 0, 1); step();
    flags(0, 0, 0);
    check("irq_mu_masked", mfl.mfl_ps_irq, 1'b0);
    rd_check("irq_mu_stky", 1, 16'h0012);

    bus_wr(1, 16'h0011);
    check("irq_bus_set", mfl.mfl_ps_irq, 1'b1);
    mfl.ps_mfl_irq_ack = 1'b1; step(); mfl.ps_mfl_irq_ack = 1'b0;
`else
    mfl.ps_mfl_irq_ack = 1'b1; step(); mfl.ps_mfl_irq_ack = 1'b0;
    check("irq_tied", mfl.mfl_ps_irq, 1'b0);
`endif

    // Reset in the execute cycle of a pending update
    issue(1, 2'b01, 2'b00, 1); step();
    issue(0, 2'b01, 2'b00, 0); flags(1, 1, 1);
    reset = 1'b0;
    model_reset();
    step();
    reset = 1'b1;
    step(); step();
    flags(0, 0, 0);
    rd_check("t6_astat", 0, 16'h0000);
    rd_check("t6_stky", 1, 16'h0000);
    check("t6_irq", mfl.mfl_ps_irq, 1'b0);
    step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
